// File: rtl/alu_flag_branch_unit.sv
// ALU flag / branch resolution stage.
// Derives N/Z/C/V from the ALU result, keeps the architectural flag register,
// resolves conditional branches and presents the decision through one
// registered valid/ready output stage. Also keeps a saturating count of
// taken branches delivered downstream.

module or32x1 (
  input  logic [15:0] or_input0,
  input  logic [15:0] or_input1,
  output logic        or_output
);

  // Reduction OR across both 16-bit halves
  always_comb begin
    or_output = (|or_input0) | (|or_input1);
  end

endmodule

module alu_flag_branch_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      alu_result,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             upd_flags,
  input  logic             is_branch,
  input  logic [2:0]       cond,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_taken,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [2:0] {
    COND_EQ     = 3'b000,
    COND_NE     = 3'b001,
    COND_LT     = 3'b010,
    COND_GE     = 3'b011,
    COND_LTU    = 3'b100,
    COND_GEU    = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  logic       or_output;
  logic       accept;
  logic       out_fire;
  logic [3:0] new_flags;
  logic [3:0] eval_flags;
  logic       cond_true;
  cond_e      cond_code;

  or32x1 u_or32x1 (
    .or_input0 (alu_result[15:0]),
    .or_input1 (alu_result[31:16]),
    .or_output (or_output)
  );

  // Handshake: stage frees up when empty or when its content is leaving
  always_comb begin
    in_ready = ~out_valid | out_ready;
    accept   = in_valid & in_ready & ~flush;
    out_fire = out_valid & out_ready;
  end

  // Flags produced by this transaction, and the set the branch sees
  // (freshly produced flags are forwarded when this transaction writes them)
  always_comb begin
    new_flags  = {alu_result[31], ~or_output, alu_carry, alu_ovf};
    eval_flags = upd_flags ? new_flags : flags;
  end

  // Branch condition decode against {N,Z,C,V}
  always_comb begin
    cond_code = cond_e'(cond);
    cond_true = 1'b0;
    case (cond_code)
      COND_EQ:     cond_true = eval_flags[2];
      COND_NE:     cond_true = ~eval_flags[2];
      COND_LT:     cond_true = eval_flags[3] ^ eval_flags[0];
      COND_GE:     cond_true = ~(eval_flags[3] ^ eval_flags[0]);
      COND_LTU:    cond_true = ~eval_flags[1];
      COND_GEU:    cond_true = eval_flags[1];
      COND_ALWAYS: cond_true = 1'b1;
      COND_NEVER:  cond_true = 1'b0;
      default:     cond_true = 1'b0;
    endcase
  end

  // Output stage register; flush drops the held result and the incoming one
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      br_taken  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      br_taken  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      br_taken  <= is_branch & cond_true;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      br_taken  <= 1'b0;
    end
  end

  // Architectural flag register, written only by accepted flag-updating ops
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else if (accept && upd_flags) begin
      flags <= new_flags;
    end
  end

  // Saturating count of taken branches handed downstream; a flushed result
  // is discarded rather than delivered, so it is not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (!flush && out_fire && br_taken && (taken_cnt != '1)) begin
      taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Scoreboard bench for alu_flag_branch_unit (instantiated with CNT_W=4 so
// counter saturation is reachable).

module tb_alu_flag_branch_unit;

  localparam int unsigned CW = 4;

  localparam logic [2:0] EQ = 3'b000, NE = 3'b001, LT = 3'b010, GE = 3'b011,
                         LTU = 3'b100, GEU = 3'b101, ALW = 3'b110, NEV = 3'b111;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   alu_result;
  logic          alu_carry;
  logic          alu_ovf;
  logic          upd_flags;
  logic          is_branch;
  logic [2:0]    cond;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          br_taken;
  logic [3:0]    flags;
  logic [CW-1:0] taken_cnt;

  alu_flag_branch_unit #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .upd_flags  (upd_flags),
    .is_branch  (is_branch),
    .cond       (cond),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .br_taken   (br_taken),
    .flags      (flags),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state
  logic          m_ov;
  logic          m_bt;
  logic [3:0]    m_flags;
  logic [CW-1:0] m_cnt;
  logic          sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [2:0] cd, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      EQ:      return z;
      NE:      return !z;
      LT:      return n != v;
      GE:      return n == v;
      LTU:     return !c;
      GEU:     return c;
      ALW:     return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] r, input logic c, input logic o,
                       input logic u, input logic b, input logic [2:0] cd,
                       input logic f, input logic ordy);
    in_valid   = v;
    alu_result = r;
    alu_carry  = c;
    alu_ovf    = o;
    upd_flags  = u;
    is_branch  = b;
    cond       = cd;
    flush      = f;
    out_ready  = ordy;
  endtask

  // Called at a negedge with inputs applied: compare, advance model, wait a cycle
  task automatic cycle();
    logic       acc;
    logic [3:0] nf;
    logic [3:0] ef;
    logic       tk;
    #1;
    check_eq("in_ready", in_ready, (!m_ov) || out_ready);
    check_eq("out_valid", out_valid, m_ov);
    check_eq("br_taken", br_taken, m_bt);
    check_eq("flags", flags, m_flags);
    check_eq("taken_cnt", taken_cnt, m_cnt);
    if (!rst && !flush && m_ov && out_ready) begin
      if (sb.size() == 0) check_eq("sb_underflow", 1, 0);
      else check_eq("sb_br_taken", br_taken, sb.pop_front());
    end
    if (rst) begin
      m_ov = 0; m_bt = 0; m_flags = '0; m_cnt = '0; sb.delete();
    end else if (flush) begin
      m_ov = 0; m_bt = 0; sb.delete();
    end else begin
      acc = in_valid && (!m_ov || out_ready);
      if (m_ov && out_ready && m_bt && (m_cnt != {CW{1'b1}})) m_cnt = m_cnt + 1'b1;
      if (acc) begin
        nf = {alu_result[31], alu_result == 32'h0, alu_carry, alu_ovf};
        ef = upd_flags ? nf : m_flags;
        tk = is_branch && cond_ok(cond, ef);
        m_ov = 1; m_bt = tk;
        sb.push_back(tk);
        if (upd_flags) m_flags = nf;
      end else if (out_ready) begin
        m_ov = 0; m_bt = 0;
      end
    end
    @(negedge clk);
  endtask

  logic [3:0]    saved_flags;
  logic [CW-1:0] saved_cnt;
  logic [31:0]   rv;
  logic [31:0]   pick[5];

  initial begin
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0, EQ, 0, 1);
    @(negedge clk);
    @(negedge clk);
    m_ov = 0; m_bt = 0; m_flags = '0; m_cnt = '0;
    rst = 1'b0;

    // Reset state
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_br_taken", br_taken, 0);
    check_eq("rst_flags", flags, 4'b0000);
    check_eq("rst_taken_cnt", taken_cnt, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Zero result sets Z
    drive(1, 32'h0000_0000, 0, 0, 1, 0, EQ, 0, 1); cycle();
    check_eq("t1_flags", flags, 4'b0100);
    check_eq("t1_out_valid", out_valid, 1);
    check_eq("t1_br_taken", br_taken, 0);

    // Non-zero only in the upper half clears Z
    drive(1, 32'h0001_0000, 0, 0, 1, 1, EQ, 0, 1); cycle();
    check_eq("t2_eq_taken", br_taken, 0);
    check_eq("t2_flags", flags, 4'b0000);
    drive(1, 32'h0001_0000, 0, 0, 1, 1, NE, 0, 1); cycle();
    check_eq("t2_ne_taken", br_taken, 1);

    // Forwarded flags vs stored flags
    drive(1, 32'h8000_0000, 0, 0, 1, 1, LT, 0, 1); cycle();
    check_eq("t3_lt_fwd", br_taken, 1);
    check_eq("t3_flags", flags, 4'b1000);
    drive(1, 32'h0000_0000, 1, 1, 0, 1, GE, 0, 1); cycle();
    check_eq("t3_ge_stored", br_taken, 0);
    check_eq("t3_flags_kept", flags, 4'b1000);

    // Back-pressure for three cycles
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1, 32'h0000_0005, 1, 0, 1, 1, GEU, 0, 0); cycle();
      check_eq("t4_in_ready", in_ready, 0);
      check_eq("t4_out_valid", out_valid, 1);
      check_eq("t4_flags", flags, 4'b1000);
    end
    // Release: one transfer per cycle
    for (int unsigned i = 0; i < 5; i++) begin
      drive(1, 32'h0000_0001 << i, i[0], 0, 1, 1, ALW - 3'(i % 3), 0, 1); cycle();
      check_eq("t4_stream_valid", out_valid, 1);
    end

    // Taken branch in the output stage, then flush with an input presented
    drive(1, 32'h0, 1, 0, 0, 1, ALW, 0, 1); cycle();
    saved_flags = m_flags;
    saved_cnt   = m_cnt;
    drive(1, 32'h0, 1, 1, 1, 1, ALW, 1, 1); cycle();
    check_eq("t5_out_valid", out_valid, 0);
    check_eq("t5_br_taken", br_taken, 0);
    check_eq("t5_flags", flags, saved_flags);
    check_eq("t5_cnt", taken_cnt, saved_cnt);

    // Randomised traffic
    pick[0] = 32'h0; pick[1] = 32'h0001_0000; pick[2] = 32'h0000_0001;
    pick[3] = 32'h8000_0000; pick[4] = 32'hFFFF_FFFF;
    for (int unsigned i = 0; i < 60; i++) begin
      rv = ($urandom_range(0, 2) == 0) ? $urandom() : pick[$urandom_range(0, 4)];
      drive($urandom_range(0, 3) != 0, rv, 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 3'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      cycle();
    end

    // Counter saturation, then reset clears it
    rst = 1'b1; drive(0, 32'h0, 0, 0, 0, 0, EQ, 0, 1); cycle();
    rst = 1'b0;
    check_eq("t6_cnt_reset", taken_cnt, 0);
    for (int unsigned i = 0; i < 17; i++) begin
      drive(1, 32'h1234, 0, 0, 0, 1, ALW, 0, 1); cycle();
    end
    drive(0, 32'h0, 0, 0, 0, 0, EQ, 0, 1); cycle();
    check_eq("t6_cnt_sat", taken_cnt, 15);
    rst = 1'b1; cycle();
    rst = 1'b0;
    check_eq("t6_cnt_cleared", taken_cnt, 0);
    check_eq("t6_flags_cleared", flags, 0);

    // Drain with a bounded wait
    drive(0, 32'h0, 0, 0, 0, 0, EQ, 0, 1);
    for (int unsigned i = 0; i < 10 && sb.size() != 0; i++) cycle();
    check_eq("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
